serial_word_receiver: RTL

//   Receive end of the serial word link: deserialises an MSB-first bitstream
//   (one bit per in_valid strobe) into WORD_SIZE-bit words. Hunts for a
//   HDR_WIDTH-bit header, then captures WORDS words per frame.

---
 rtl/serial_word_receiver_if.sv | 21 ++
 rtl/serial_word_receiver.sv | 139 +++++++++++++
 2 files changed

// File: rtl/serial_word_receiver_if.sv
// Stream interface of the serial word receiver: bit-serial input side and
// valid/ready word output side.
interface serial_word_receiver_if #(
  parameter int WORD_SIZE = 27
);
  logic                 serialIn;
  logic                 in_valid;
  logic [WORD_SIZE-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  serialIn, in_valid, out_ready,
    output out_data, out_valid
  );

  modport master (
    output serialIn, in_valid, out_ready,
    input  out_data, out_valid
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial word receiver: hunts for a header in an MSB-first bitstream, then
// deserialises WORDS words per frame into a small valid/ready output FIFO.
module serial_word_receiver #(
  parameter int                   WORD_SIZE   = 27,
  parameter int                   WORDS       = 3,
  parameter int                   HDR_WIDTH   = 8,
  parameter logic [HDR_WIDTH-1:0] HDR_PATTERN = 8'hA5,
  parameter int                   FIFO_DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  serial_word_receiver_if.slave   bus,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    overflow
);

  localparam int BCW = $clog2(WORD_SIZE);
  localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  localparam logic [BCW-1:0] BIT_RELOAD = BCW'(WORD_SIZE - 1);
  localparam logic [WCW-1:0] LAST_WORD  = WCW'(WORDS - 1);

  typedef enum logic {
    HUNT,
    RECV
  } state_t;

  state_t                r_state;
  // The oldest bit of each shift register is never needed again: the match
  // and the completed word are both formed from the incoming bit, so only
  // the younger bits are stored.
  logic [HDR_WIDTH-2:0]  r_hdr_shift;
  logic [WORD_SIZE-2:0]  r_word_shift;
  logic [BCW-1:0]        r_bit_cnt;
  logic [WCW-1:0]        r_word_cnt;
  logic [WORD_SIZE-1:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_frame_done;
  logic                  r_overflow;

  logic [HDR_WIDTH-1:0]  w_hdr_next;
  logic [WORD_SIZE-1:0]  w_word_next;
  logic                  w_word_done;
  logic                  w_pop;
  logic                  w_push;

  assign w_hdr_next  = {r_hdr_shift, bus.serialIn};
  assign w_word_next = {r_word_shift, bus.serialIn};
  assign w_word_done = bus.in_valid && (r_state == RECV) && (r_bit_cnt == '0);
  // A pop frees a slot in the same edge, so a full FIFO still accepts a push.
  assign w_pop       = !clear && (r_count != '0) && bus.out_ready;
  assign w_push      = !clear && w_word_done && ((r_count < CW'(FIFO_DEPTH)) || w_pop);

  // NOTE: FIFO storage has no reset; out_data is forced to 0 while empty,
  // so stale entries are never observable and the array maps to plain RAM.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= HUNT;
      r_hdr_shift  <= '0;
      r_word_shift <= '0;
      r_bit_cnt    <= BIT_RELOAD;
      r_word_cnt   <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (clear) begin
      r_state      <= HUNT;
      r_hdr_shift  <= '0;
      r_word_shift <= '0;
      r_bit_cnt    <= BIT_RELOAD;
      r_word_cnt   <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
      // Frame counting continues even when the word itself is dropped.
      if (w_word_done && !w_push) r_overflow <= 1'b1;

      if (bus.in_valid) begin
        unique case (r_state)
          HUNT: begin
            r_hdr_shift <= w_hdr_next[HDR_WIDTH-2:0];
            if (w_hdr_next == HDR_PATTERN) begin
              r_state    <= RECV;
              r_bit_cnt  <= BIT_RELOAD;
              r_word_cnt <= '0;
            end
          end
          RECV: begin
            r_word_shift <= w_word_next[WORD_SIZE-2:0];
            if (r_bit_cnt == '0) begin
              r_bit_cnt <= BIT_RELOAD;
              if (r_word_cnt == LAST_WORD) begin
                r_frame_done <= 1'b1;
                r_state      <= HUNT;
                r_hdr_shift  <= '0;
                r_word_cnt   <= '0;
              end else begin
                r_word_cnt <= r_word_cnt + WCW'(1);
              end
            end else begin
              r_bit_cnt <= r_bit_cnt - BCW'(1);
            end
          end
        endcase
      end
    end
  end

  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign frame_done    = r_frame_done;
  assign busy          = (r_state == RECV);
  assign overflow      = r_overflow;

endmodule
